round_controller: RTL and testbench
===================================

# round_controller

Multi-round scheduler for the baccarat hand datapath. It starts each hand, gates step requests to the per-hand state machine, and holds that state machine and the card datapath in reset between hands. It tracks cards left in the shoe and forces a timed reshuffle before a hand when the shoe runs low. It keeps saturating tallies of player wins, dealer wins, ties and rounds for the display logic.

## Interface
- SHOE_CARDS, 52, cards in a fresh shoe; must be 1..63.
- RESHUFFLE_THRESHOLD, 6, a new hand needs at least this many cards left; otherwise the shoe is reshuffled first.
- SHUFFLE_CYCLES, 8, length of the reshuffle in slow_clock cycles; must be ≥1.
- TALLY_W, 8, width of every tally counter.
- slow_clock  in  1  sole clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle advance request, already synchronized and edge-detected upstream.
- round_done  in  1  hand state machine is in its final state.
- player_win_light  in  1  win light from the hand state machine.
- dealer_win_light  in  1  win light from the hand state machine.
- card_loaded  in  1  one-cycle pulse: one card drawn (OR of all six load strobes).
- round_resetb  out  1  registered active-low reset to the hand state machine and card datapath.
- hand_step  out  1  combinational step enable forwarded to the hand state machine.
- reshuffle  out  1  high for the whole reshuffle.
- busy  out  1  high in every state except IDLE and DONE.
- fault  out  1  sticky error flag; cleared only by resetb.
- cards_left  out  6  cards remaining in the shoe.
- player_wins, dealer_wins, ties, rounds  out  TALLY_W each  saturating tallies.

## Operation
- States: IDLE, SHUFFLE, CLEAR, PLAY, SCORE, DONE.
- Reset values: state IDLE, round_resetb 0, reshuffle 0, fault 0, cards_left SHOE_CARDS, all tallies 0, shuffle counter 0.
- IDLE: round_resetb 0. On step, go to SHUFFLE if cards_left < RESHUFFLE_THRESHOLD, else go to CLEAR.
- SHUFFLE: reshuffle 1. The counter loads SHUFFLE_CYCLES−1 on entry and decrements each cycle. When it reaches 0, cards_left ← SHOE_CARDS and the state goes to CLEAR. Total time in SHUFFLE is exactly SHUFFLE_CYCLES cycles.
- CLEAR: round_resetb 0 for exactly one cycle, then PLAY.
- PLAY: round_resetb 1; hand_step = step & ~round_done.
  - Each card_loaded pulse decrements cards_left.
  - A card_loaded pulse at cards_left = 0 holds cards_left at 0 and sets fault.
  - round_done = 1 moves to SCORE.
- SCORE: one cycle; samples the win lights and updates tallies:
  - Both lights on: ties+1.
  - Player light only: player_wins+1.
  - Dealer light only: dealer_wins+1.
  - Neither light on: no win/tie tally change, and fault is set.
  - rounds+1 in every case.
  - Every tally saturates at 2^TALLY_W−1.
  - Then the state goes to DONE.
- DONE: round_resetb stays 1 so the hand result and lights stay visible. On step, go to SHUFFLE if cards_left < RESHUFFLE_THRESHOLD, else go to CLEAR.
- step is ignored in SHUFFLE, CLEAR and SCORE.
- hand_step is 0 outside PLAY.
- card_loaded is ignored outside PLAY.
- Simultaneous events: step together with round_done in PLAY moves to SCORE with hand_step 0.

## Timing
- round_resetb comes from a flop: it deasserts on the edge that enters PLAY and asserts on the edge that enters CLEAR or IDLE.
- hand_step has zero latency from step, so the hand state machine advances on the same edge that samples step.
- Latency from a step in IDLE/DONE to the first hand_step opportunity:
  - 2 edges when no reshuffle is needed (→CLEAR, →PLAY).
  - SHUFFLE_CYCLES+2 edges when a reshuffle is needed.
- Tallies and rounds update on the edge leaving SCORE, one cycle after round_done was sampled.
- Asserting resetb at any time, including mid-hand or mid-shuffle, returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset, then hold step low for 10 cycles -> round_resetb=0, busy=0, cards_left=52, all tallies 0, fault=0.
- Start a hand and pulse card_loaded 4 times, then raise round_done with player light only -> cards_left=48, player_wins=1, rounds=1, state DONE, round_resetb=1.
- Drive lights both on at round_done -> ties increments by 1, player_wins unchanged; with neither light on -> fault=1, rounds still increments.
- Drain cards_left to 5, then step in DONE -> reshuffle high for exactly 8 cycles, cards_left=52, then one cycle of round_resetb=0, then PLAY.
- Assert resetb in PLAY with cards_left=40 and player_wins=3 -> all outputs return to reset values asynchronously.
- Force player_wins to 255 and score another player win -> player_wins stays 255 and rounds increments; a card_loaded pulse at cards_left=0 keeps 0 and sets fault.

Source files
------------

// File: rtl/round_controller.sv
// Multi-round scheduler for the baccarat hand datapath: sequences hands, tracks the
// shoe with timed reshuffles, and keeps saturating win/tie/round tallies.
module round_controller #(
    parameter int SHOE_CARDS          = 52,
    parameter int RESHUFFLE_THRESHOLD = 6,
    parameter int SHUFFLE_CYCLES      = 8,
    parameter int TALLY_W             = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               step,
    input  logic               round_done,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    input  logic               card_loaded,
    output logic               round_resetb,
    output logic               hand_step,
    output logic               reshuffle,
    output logic               busy,
    output logic               fault,
    output logic [5:0]         cards_left,
    output logic [TALLY_W-1:0] player_wins,
    output logic [TALLY_W-1:0] dealer_wins,
    output logic [TALLY_W-1:0] ties,
    output logic [TALLY_W-1:0] rounds
);

    localparam int               CNT_W     = (SHUFFLE_CYCLES > 1) ? $clog2(SHUFFLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SHUFFLE_CYCLES - 1);
    localparam logic [5:0]       SHOE_FULL = 6'(SHOE_CARDS);
    localparam logic [6:0]       THRESH    = 7'(RESHUFFLE_THRESHOLD);
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    typedef enum logic [2:0] {IDLE, SHUFFLE, CLEAR, PLAY, SCORE, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   shuffle_cnt_q, shuffle_cnt_d;
    logic               round_resetb_q, round_resetb_d;
    logic               fault_q, fault_d;
    logic [5:0]         cards_left_q, cards_left_d;
    logic [TALLY_W-1:0] player_wins_q, player_wins_d;
    logic [TALLY_W-1:0] dealer_wins_q, dealer_wins_d;
    logic [TALLY_W-1:0] ties_q, ties_d;
    logic [TALLY_W-1:0] rounds_q, rounds_d;
    logic               need_shuffle;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == TALLY_MAX) ? v : v + TALLY_W'(1);
    endfunction

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= IDLE;
            shuffle_cnt_q  <= '0;
            round_resetb_q <= 1'b0;
            fault_q        <= 1'b0;
            cards_left_q   <= SHOE_FULL;
            player_wins_q  <= '0;
            dealer_wins_q  <= '0;
            ties_q         <= '0;
            rounds_q       <= '0;
        end else begin
            state_q        <= state_d;
            shuffle_cnt_q  <= shuffle_cnt_d;
            round_resetb_q <= round_resetb_d;
            fault_q        <= fault_d;
            cards_left_q   <= cards_left_d;
            player_wins_q  <= player_wins_d;
            dealer_wins_q  <= dealer_wins_d;
            ties_q         <= ties_d;
            rounds_q       <= rounds_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shuffle_cnt_d  = shuffle_cnt_q;
        round_resetb_d = round_resetb_q;
        fault_d        = fault_q;
        cards_left_d   = cards_left_q;
        player_wins_d  = player_wins_q;
        dealer_wins_d  = dealer_wins_q;
        ties_d         = ties_q;
        rounds_d       = rounds_q;
        hand_step      = 1'b0;
        need_shuffle   = {1'b0, cards_left_q} < THRESH;

        case (state_q)
            IDLE, DONE: begin
                if (step) begin
                    if (need_shuffle) begin
                        state_d       = SHUFFLE;
                        shuffle_cnt_d = CNT_LOAD;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            SHUFFLE: begin
                if (shuffle_cnt_q == '0) begin
                    cards_left_d = SHOE_FULL;
                    state_d      = CLEAR;
                end else begin
                    shuffle_cnt_d = shuffle_cnt_q - CNT_W'(1);
                end
            end
            CLEAR: state_d = PLAY;
            PLAY: begin
                hand_step = step & ~round_done;
                // Drawing from an empty shoe is an upstream error; hold at zero.
                if (card_loaded) begin
                    if (cards_left_q == '0) fault_d = 1'b1;
                    else                    cards_left_d = cards_left_q - 6'd1;
                end
                if (round_done) state_d = SCORE;
            end
            SCORE: begin
                case ({player_win_light, dealer_win_light})
                    2'b11:   ties_d        = sat_inc(ties_q);
                    2'b10:   player_wins_d = sat_inc(player_wins_q);
                    2'b01:   dealer_wins_d = sat_inc(dealer_wins_q);
                    default: fault_d       = 1'b1;
                endcase
                rounds_d = sat_inc(rounds_q);
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Hand datapath is released only for PLAY; it stays out of reset through
        // DONE (and any following shuffle) so results remain visible.
        if (state_d == CLEAR || state_d == IDLE) round_resetb_d = 1'b0;
        else if (state_d == PLAY)                round_resetb_d = 1'b1;
    end

    assign round_resetb = round_resetb_q;
    assign reshuffle    = (state_q == SHUFFLE);
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign fault        = fault_q;
    assign cards_left   = cards_left_q;
    assign player_wins  = player_wins_q;
    assign dealer_wins  = dealer_wins_q;
    assign ties         = ties_q;
    assign rounds       = rounds_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: a cycle-level behavioural model of the
// round scheduler plus directed hands with hand-computed expectations.
module tb_round_controller;

    localparam int SHOE = 52;
    localparam int THR  = 6;
    localparam int SHUF = 8;
    localparam int TW   = 8;
    localparam int TMAX = (1 << TW) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_SHUF  = 1;
    localparam int PH_CLEAR = 2;
    localparam int PH_PLAY  = 3;
    localparam int PH_SCORE = 4;
    localparam int PH_DONE  = 5;

    logic          slow_clock = 1'b0;
    logic          resetb = 1'b0;
    logic          step = 1'b0;
    logic          round_done = 1'b0;
    logic          player_win_light = 1'b0;
    logic          dealer_win_light = 1'b0;
    logic          card_loaded = 1'b0;
    logic          round_resetb, hand_step, reshuffle, busy, fault;
    logic [5:0]    cards_left;
    logic [TW-1:0] player_wins, dealer_wins, ties, rounds;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int m_phase = PH_IDLE;
    int m_cards = SHOE;
    int m_shuf_left = 0;
    int m_pw = 0, m_dw = 0, m_ties = 0, m_rounds = 0;
    bit m_fault = 1'b0;
    bit m_rr = 1'b0;

    round_controller #(
        .SHOE_CARDS(SHOE), .RESHUFFLE_THRESHOLD(THR), .SHUFFLE_CYCLES(SHUF), .TALLY_W(TW)
    ) dut (
        .slow_clock(slow_clock), .resetb(resetb), .step(step), .round_done(round_done),
        .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
        .card_loaded(card_loaded), .round_resetb(round_resetb), .hand_step(hand_step),
        .reshuffle(reshuffle), .busy(busy), .fault(fault), .cards_left(cards_left),
        .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties), .rounds(rounds)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit c, input bit rd, input bit pl, input bit dl);
        step             = s;
        card_loaded      = c;
        round_done       = rd;
        player_win_light = pl;
        dealer_win_light = dl;
        @(posedge slow_clock);
        #1;
        step             = 1'b0;
        card_loaded      = 1'b0;
        round_done       = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
    endtask

    // Reference model: hand lifecycle tracked by phase, shoe by remaining cards,
    // shuffle by cycles still to spend.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            m_phase     <= PH_IDLE;
            m_cards     <= SHOE;
            m_shuf_left <= 0;
            m_pw        <= 0;
            m_dw        <= 0;
            m_ties      <= 0;
            m_rounds    <= 0;
            m_fault     <= 1'b0;
            m_rr        <= 1'b0;
        end else begin
            if ((m_phase == PH_IDLE || m_phase == PH_DONE) && step) begin
                if (m_cards < THR) begin
                    m_phase     <= PH_SHUF;
                    m_shuf_left <= SHUF;
                end else begin
                    m_phase <= PH_CLEAR;
                    m_rr    <= 1'b0;
                end
            end else if (m_phase == PH_SHUF) begin
                m_shuf_left <= m_shuf_left - 1;
                if (m_shuf_left == 1) begin
                    m_cards <= SHOE;
                    m_phase <= PH_CLEAR;
                    m_rr    <= 1'b0;
                end
            end else if (m_phase == PH_CLEAR) begin
                m_phase <= PH_PLAY;
                m_rr    <= 1'b1;
            end else if (m_phase == PH_PLAY) begin
                if (card_loaded) begin
                    if (m_cards == 0) m_fault <= 1'b1;
                    else              m_cards <= m_cards - 1;
                end
                if (round_done) m_phase <= PH_SCORE;
            end else if (m_phase == PH_SCORE) begin
                if (player_win_light && dealer_win_light) m_ties <= (m_ties < TMAX) ? m_ties + 1 : TMAX;
                else if (player_win_light)                m_pw   <= (m_pw < TMAX) ? m_pw + 1 : TMAX;
                else if (dealer_win_light)                m_dw   <= (m_dw < TMAX) ? m_dw + 1 : TMAX;
                else                                      m_fault <= 1'b1;
                m_rounds <= (m_rounds < TMAX) ? m_rounds + 1 : TMAX;
                m_phase  <= PH_DONE;
            end
        end
    end

    always @(negedge slow_clock) begin
        if (cmp_en) begin
            checkOutput("m_round_resetb", round_resetb, m_rr);
            checkOutput("m_hand_step", hand_step, (m_phase == PH_PLAY && step && !round_done) ? 1 : 0);
            checkOutput("m_reshuffle", reshuffle, (m_phase == PH_SHUF) ? 1 : 0);
            checkOutput("m_busy", busy, (m_phase != PH_IDLE && m_phase != PH_DONE) ? 1 : 0);
            checkOutput("m_fault", fault, m_fault);
            checkOutput("m_cards_left", cards_left, m_cards);
            checkOutput("m_player_wins", player_wins, m_pw);
            checkOutput("m_dealer_wins", dealer_wins, m_dw);
            checkOutput("m_ties", ties, m_ties);
            checkOutput("m_rounds", rounds, m_rounds);
        end
    end

    task automatic play_hand(input int ncards, input bit pl, input bit dl);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_phase != PH_PLAY; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (m_phase != PH_PLAY) begin
            failures++;
            $display("[TB] FAIL reach_play: phase %0d expected %0d (timeout)", m_phase, PH_PLAY);
        end
        repeat (ncards) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, pl, dl);
        applyStimulus(1'b0, 1'b0, 1'b1, pl, dl);
    endtask

    initial begin
        int shuf_cnt;
        repeat (3) @(posedge slow_clock);
        #1;
        resetb = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] idle after reset");
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_round_resetb", round_resetb, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_cards", cards_left, 52);
        checkOutput("idle_fault", fault, 0);
        checkOutput("idle_rounds", rounds, 0);
        checkOutput("idle_player_wins", player_wins, 0);

        $display("[TB] first hand, four cards, player win");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_round_resetb", round_resetb, 0);
        checkOutput("clear_busy", busy, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("play_round_resetb", round_resetb, 1);
        step = 1'b1;
        #1;
        checkOutput("play_hand_step", hand_step, 1);
        step = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cards_after_4", cards_left, 48);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("h1_player_wins", player_wins, 1);
        checkOutput("h1_rounds", rounds, 1);
        checkOutput("h1_busy_done", busy, 0);
        checkOutput("h1_round_resetb", round_resetb, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("done_card_ignored", cards_left, 48);

        $display("[TB] tie, no-light and dealer hands");
        play_hand(0, 1'b1, 1'b1);
        checkOutput("h2_ties", ties, 1);
        checkOutput("h2_player_wins", player_wins, 1);
        play_hand(0, 1'b0, 1'b0);
        checkOutput("h3_fault", fault, 1);
        checkOutput("h3_rounds", rounds, 3);
        checkOutput("h3_ties", ties, 1);
        play_hand(0, 1'b0, 1'b1);
        checkOutput("h4_dealer_wins", dealer_wins, 1);

        $display("[TB] drain shoe and reshuffle");
        play_hand(43, 1'b1, 1'b0);
        checkOutput("drain_cards", cards_left, 5);
        checkOutput("drain_player_wins", player_wins, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        shuf_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!reshuffle) break;
            shuf_cnt++;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("reshuffle_cycles", shuf_cnt, 8);
        checkOutput("reshuffle_cards", cards_left, 52);
        checkOutput("post_shuffle_round_resetb", round_resetb, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_clear_round_resetb", round_resetb, 1);

        $display("[TB] async reset mid-hand");
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_cards", cards_left, 40);
        checkOutput("pre_reset_player_wins", player_wins, 3);
        checkOutput("pre_reset_round_resetb", round_resetb, 1);
        #2;
        resetb = 1'b0;
        #1;
        checkOutput("arst_round_resetb", round_resetb, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_cards", cards_left, 52);
        checkOutput("arst_player_wins", player_wins, 0);
        checkOutput("arst_rounds", rounds, 0);
        checkOutput("arst_fault", fault, 0);
        checkOutput("arst_ties", ties, 0);
        @(posedge slow_clock);
        #1;
        resetb = 1'b1;

        $display("[TB] tally saturation");
        repeat (255) play_hand(0, 1'b1, 1'b0);
        checkOutput("sat_player_wins", player_wins, 255);
        checkOutput("sat_rounds", rounds, 255);
        play_hand(0, 1'b1, 1'b0);
        checkOutput("sat_hold_player_wins", player_wins, 255);
        checkOutput("sat_hold_rounds", rounds, 255);
        checkOutput("sat_fault_clear", fault, 0);

        $display("[TB] draw from empty shoe");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (52) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("empty_cards", cards_left, 0);
        checkOutput("empty_fault_before", fault, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("empty_cards_hold", cards_left, 0);
        checkOutput("empty_fault_set", fault, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("final_cards", cards_left, 52);
        checkOutput("final_dealer_wins", dealer_wins, 1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
